// File: rtl/vga_scan_controller.sv
// Raster-scan timing source for a VGA DAC: pixel counters, registered blanked RGB,
// sync pulses aligned with the pixel data, and a per-frame strobe for game logic.
module vga_scan_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pix_en_q;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic       fs_q, fs_d;
  logic       visible, hs_win, vs_win;

  assign visible = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign hs_win  = (hc_q >= H_SYNC_LO) && (hc_q < H_SYNC_HI);
  assign vs_win  = (vc_q >= V_SYNC_LO) && (vc_q < V_SYNC_HI);

  always_comb begin
    hc_d      = hc_q;
    vc_d      = vc_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    fs_d      = 1'b0;
    if (pix_en_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
      // Output stage samples the pre-increment position: one pixel behind DrawX/DrawY.
      r_d       = visible ? Red   : 8'd0;
      g_d       = visible ? Green : 8'd0;
      b_d       = visible ? Blue  : 8'd0;
      blank_n_d = visible;
      hs_d      = ~hs_win;
      vs_d      = ~vs_win;
      fs_d      = (hc_q == 10'd0) && (vc_q == 10'd0);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en_q  <= 1'b0;
      hc_q      <= '0;
      vc_q      <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      pix_en_q  <= ~pix_en_q;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      fs_q      <= fs_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = pix_en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: full-size line timing and alignment, plus a
// small-parameter instance for whole-frame timing and mid-frame reset.
module tb_vga_scan_controller;

  logic       Clk = 1'b0;
  logic       rst, s_rst;
  logic       ff_mode;
  logic [7:0] red, s_red;
  logic [9:0] drawx, drawy, s_drawx, s_drawy;
  logic [7:0] vga_r, vga_g, vga_b, s_r, s_g, s_b;
  logic       hs, vs, blank_n, sync_n, vclk, fs;
  logic       s_hs, s_vs, s_blank_n, s_sync_n, s_vclk, s_fs;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  assign red   = ff_mode ? 8'hFF : drawx[7:0];
  assign s_red = s_drawx[7:0];

  vga_scan_controller dut (
    .Clk(Clk), .Reset(rst), .Red(red), .Green(red), .Blue(~red),
    .DrawX(drawx), .DrawY(drawy), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank_n), .VGA_SYNC_N(sync_n),
    .VGA_CLK(vclk), .frame_start(fs)
  );

  vga_scan_controller #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) sdut (
    .Clk(Clk), .Reset(s_rst), .Red(s_red), .Green(s_red), .Blue(~s_red),
    .DrawX(s_drawx), .DrawY(s_drawy), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_blank_n), .VGA_SYNC_N(s_sync_n),
    .VGA_CLK(s_vclk), .frame_start(s_fs)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // n = Clk edges after reset release; remaining fields are expected outputs.
  typedef struct {
    int n; int x; int y; int r; int b; int hs; int vs; int fs; int vclk;
  } vec_t;

  vec_t tv[16];

  initial begin
    int edges_done, g, cnt, bad, vs_lo, hs_lo, vis;

    tv[0]  = '{1,    0,   0, 0,   0, 1, 1, 0, 1};
    tv[1]  = '{2,    1,   0, 0,   1, 1, 1, 1, 0};
    tv[2]  = '{3,    1,   0, 0,   1, 1, 1, 0, 1};
    tv[3]  = '{4,    2,   0, 1,   1, 1, 1, 0, 0};
    tv[4]  = '{200,  100, 0, 99,  1, 1, 1, 0, 0};
    tv[5]  = '{1280, 640, 0, 127, 1, 1, 1, 0, 0};
    tv[6]  = '{1282, 641, 0, 0,   0, 1, 1, 0, 0};
    tv[7]  = '{1312, 656, 0, 0,   0, 1, 1, 0, 0};
    tv[8]  = '{1314, 657, 0, 0,   0, 0, 1, 0, 0};
    tv[9]  = '{1504, 752, 0, 0,   0, 0, 1, 0, 0};
    tv[10] = '{1506, 753, 0, 0,   0, 1, 1, 0, 0};
    tv[11] = '{1598, 799, 0, 0,   0, 1, 1, 0, 0};
    tv[12] = '{1600, 0,   1, 0,   0, 1, 1, 0, 0};
    tv[13] = '{1602, 1,   1, 0,   1, 1, 1, 0, 0};
    tv[14] = '{1604, 2,   1, 1,   1, 1, 1, 0, 0};
    tv[15] = '{1861, 130, 1, 129, 1, 1, 1, 0, 1};

    rst = 1'b1; s_rst = 1'b1; ff_mode = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_drawx", int'(drawx), 0);
    chk("rst_drawy", int'(drawy), 0);
    chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("rst_hs_vs", int'({hs, vs}), 3);
    chk("rst_blank_n", int'(blank_n), 0);
    chk("rst_fs", int'(fs), 0);
    chk("rst_vclk", int'(vclk), 0);
    chk("sync_n", int'(sync_n), 0);
    chk("s_rst_rgb", int'({s_r, s_g, s_b}), 0);
    chk("s_rst_misc", int'({s_hs, s_vs, s_blank_n, s_sync_n, s_vclk, s_fs}), 6'b110000);

    rst = 1'b0;
    edges_done = 0;
    foreach (tv[i]) begin
      repeat (tv[i].n - edges_done) @(posedge Clk);
      edges_done = tv[i].n;
      @(negedge Clk);
      chk($sformatf("drawx@%0d", tv[i].n), int'(drawx), tv[i].x);
      chk($sformatf("drawy@%0d", tv[i].n), int'(drawy), tv[i].y);
      chk($sformatf("vga_r@%0d", tv[i].n), int'(vga_r), tv[i].r);
      chk($sformatf("blank_n@%0d", tv[i].n), int'(blank_n), tv[i].b);
      chk($sformatf("hs@%0d", tv[i].n), int'(hs), tv[i].hs);
      chk($sformatf("vs@%0d", tv[i].n), int'(vs), tv[i].vs);
      chk($sformatf("fs@%0d", tv[i].n), int'(fs), tv[i].fs);
      chk($sformatf("vclk@%0d", tv[i].n), int'(vclk), tv[i].vclk);
    end

    // Line timing with a constant white input, measured on the next full line.
    ff_mode = 1'b1;
    g = 0;
    while (blank_n && g < 2000) begin @(negedge Clk); g++; end
    chk("wait_blank_fall", int'(blank_n), 0);
    g = 0;
    while (!blank_n && g < 2000) begin @(negedge Clk); g++; end
    chk("wait_blank_rise", int'(blank_n), 1);
    cnt = 0; bad = 0;
    while (blank_n && cnt < 2000) begin
      if (vga_r != 8'hFF) bad++;
      @(negedge Clk); cnt++;
    end
    chk("blank_high_clks", cnt, 1280);
    chk("white_r_errors", bad, 0);
    chk("r_after_blank", int'(vga_r), 0);
    cnt = 0;
    while (hs && cnt < 2000) begin @(negedge Clk); cnt++; end
    chk("blank_to_hs_clks", cnt, 32);
    cnt = 0;
    while (!hs && cnt < 2000) begin @(negedge Clk); cnt++; end
    chk("hs_low_clks", cnt, 192);

    // Mid-line reset.
    g = 0;
    while (drawx != 10'd300 && g < 4000) begin @(negedge Clk); g++; end
    chk("wait_x300", int'(drawx), 300);
    rst = 1'b1;
    @(negedge Clk);
    chk("mid_rst_xy", int'({drawx, drawy}), 0);
    chk("mid_rst_hs_vs", int'({hs, vs}), 3);
    chk("mid_rst_blank", int'({blank_n, vga_r}), 0);
    rst = 1'b0;
    repeat (2) @(negedge Clk);
    chk("restart_fs", int'(fs), 1);
    chk("restart_drawx", int'(drawx), 1);

    // Small-parameter frame: period 196 Clk; window counts from the formulas.
    s_rst = 1'b0;
    g = 0;
    while (!s_fs && g < 50) begin @(negedge Clk); g++; end
    chk("s_first_fs", int'(s_fs), 1);
    cnt = 0; vs_lo = 0; hs_lo = 0; vis = 0;
    do begin
      if (!s_vs) vs_lo++;
      if (!s_hs) hs_lo++;
      if (s_blank_n) vis++;
      @(negedge Clk); cnt++;
    end while (!s_fs && cnt < 400);
    chk("s_frame_period", cnt, 196);
    chk("s_vs_low_clks", vs_lo, 28);
    chk("s_hs_low_clks", hs_lo, 28);
    chk("s_visible_clks", vis, 64);

    g = 0;
    while (!(s_drawy == 10'd5 && s_drawx == 10'd0) && g < 400) begin @(negedge Clk); g++; end
    chk("s_wait_y5", int'(s_drawy), 5);
    repeat (2) @(negedge Clk);
    chk("s_vs_line5", int'(s_vs), 0);

    // Mid-frame reset on the small instance.
    g = 0;
    while (!(s_drawy == 10'd3 && s_drawx == 10'd5) && g < 400) begin @(negedge Clk); g++; end
    chk("s_wait_pos", int'({s_drawy, s_drawx}), (3 << 10) | 5);
    s_rst = 1'b1;
    @(negedge Clk);
    chk("s_mid_rst_xy", int'({s_drawx, s_drawy}), 0);
    chk("s_mid_rst_hs_vs", int'({s_hs, s_vs}), 3);
    s_rst = 1'b0;
    repeat (2) @(negedge Clk);
    chk("s_restart_fs", int'(s_fs), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
